game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the character datapath. Generates the common 60 Hz frame tick and runs the IDLE/PLAY/PAUSE/OVER game-state machine. It gates raw player buttons into the character controller's step inputs and tracks lives with a post-hit invulnerability window. It also pulses a character-reset line on game start and on every respawn. Sits between the keyboard/button front-end and the character controller and renderer.

## Interface
- CLK_HZ, 65_000_000: system clock frequency.
- FRAME_HZ, 60: frame-tick rate; period P = CLK_HZ/FRAME_HZ cycles (integer, ≥2).
- LIVES, 3: lives at game start (1..3).
- INVULN_FRAMES, 90: frames during which hits are ignored after a respawn (1..255).

- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_left, btn_right, btn_jump  in  1 each  level button inputs, already synchronised to clk.
- btn_start, btn_pause  in  1 each  level buttons, synchronised; acted on at the rising edge only.
- player_hit  in  1  single-cycle pulse meaning the character was damaged.
- frame_tick  out  1  one-cycle pulse once every P cycles.
- stepleft, stepright, stepjump  out  1 each  registered step levels to the character controller.
- char_rst  out  1  one-cycle pulse that returns the character to its spawn point.
- game_state  out  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- lives  out  2  remaining lives.

## Operation
- **Frame counter:** counts 0..P-1 in every state and wraps to 0. Width is $clog2(P). frame_tick is registered high during the cycle after count==P-1.
- **Edge detection:** the previous values of btn_start and btn_pause are registered. An event is `btn & ~btn_prev`. A button held through reset produces no event.
- **IDLE:**
  - start event → PLAY.
  - In the same transition: lives←LIVES, invuln←0, char_rst pulses.
- **PLAY:** events are evaluated in this priority order:
  1. Accepted hit (player_hit & invuln==0):
     - If lives==1: lives←0 and go to OVER. A pause event in the same cycle is ignored.
     - Otherwise: lives←lives-1, char_rst pulses, invuln←INVULN_FRAMES. A pause event in the same cycle still moves to PAUSE.
  2. Pause event (no hit) → PAUSE.
  3. Otherwise stay in PLAY. invuln decrements by 1 on each frame_tick and saturates at 0.
- **PAUSE:**
  - Pause or start event → PLAY.
  - player_hit is ignored. invuln is frozen.
- **OVER:**
  - Start event → IDLE. lives holds 0 until the next game starts.
- **Step gating:**
  - Outside PLAY all three step outputs are 0.
  - In PLAY: stepleft = btn_left & ~btn_right; stepright = btn_right & ~btn_left; stepjump = btn_jump.
  - Left and right pressed together give no horizontal step.
- **Widths:** invuln is an 8-bit counter. lives never underflows below 0 and never exceeds LIVES.

## Timing
- **Reset values:**
  - game_state=IDLE, lives=LIVES, invuln=0.
  - frame_tick, char_rst and all step outputs = 0.
  - Frame counter = 0; button history registers = 0.
- All outputs are registered.
- A button edge at cycle N changes game_state and char_rst at N+1.
- The step outputs follow the button levels with 1-cycle latency. They drop to 0 in the cycle game_state leaves PLAY.
- The first frame_tick after reset is high in cycle P, counting the first cycle after reset release as cycle 0. Ticks then repeat every P cycles.
- The frame counter is never paused or reset by a game-state change.
- Reset asserted mid-game returns to reset values immediately (asynchronous).
- char_rst is high for exactly 1 cycle per event, never for 2 consecutive cycles.

## Test plan
Bench parameters: CLK_HZ=100, FRAME_HZ=10 (P=10), LIVES=3, INVULN_FRAMES=2.
- **Reset and ticks:** release reset → frame_tick high in cycles 10, 20, 30, each for exactly 1 cycle. game_state=0, lives=3, steps=0.
- **Start and steps:** hold btn_start for 5 cycles → a single transition to PLAY and one char_rst pulse. btn_left=btn_right=1 → stepleft=stepright=0. btn_right only → stepright=1 one cycle later.
- **Invulnerability:**
  - hit → lives=2, char_rst pulse.
  - second hit before 2 frame_ticks → ignored, lives stays 2.
  - hit after 2 ticks → lives=1.
- **Game over:** hit with lives=1 and pause in the same cycle → game_state=3, lives=0, steps=0, no char_rst. Start event → game_state=0.
- **Pause:**
  - pause event → game_state=2. A hit during PAUSE leaves lives unchanged, and the invuln count does not advance across ticks.
  - pause event → game_state=1.
- **Reset mid-game:** assert rst_n=0 in PLAY with lives=1 → immediate game_state=0, lives=3, outputs 0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer: free-running frame tick, IDLE/PLAY/PAUSE/OVER state machine,
// step gating, lives and post-hit invulnerability window.
module game_ctrl #(
  parameter int CLK_HZ        = 65_000_000,
  parameter int FRAME_HZ      = 60,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       player_hit,
  output logic       frame_tick,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       char_rst,
  output logic [1:0] game_state,
  output logic [1:0] lives
);
  localparam int P  = CLK_HZ / FRAME_HZ;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(P - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [7:0]    INV_INIT   = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    invuln, invuln_nxt;
  logic [1:0]    lives_nxt;
  logic          crst_nxt;
  logic          start_prev, pause_prev, armed;
  logic          start_ev, pause_ev, hit_ok;

  // armed stays low for the first cycle after reset so a button held
  // through reset is absorbed into the history registers, not seen as an edge
  assign start_ev   = armed & btn_start & ~start_prev;
  assign pause_ev   = armed & btn_pause & ~pause_prev;
  assign hit_ok     = player_hit & (invuln == 8'd0);
  assign game_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    lives_nxt  = lives;
    invuln_nxt = invuln;
    crst_nxt   = 1'b0;
    case (state)
      IDLE: if (start_ev) begin
        state_nxt  = PLAY;
        lives_nxt  = LIVES_INIT;
        invuln_nxt = 8'd0;
        crst_nxt   = 1'b1;
      end
      PLAY: begin
        if (hit_ok) begin
          if (lives == 2'd1) begin
            lives_nxt = 2'd0;
            state_nxt = OVER;
          end else begin
            lives_nxt  = lives - 2'd1;
            crst_nxt   = 1'b1;
            invuln_nxt = INV_INIT;
            if (pause_ev) state_nxt = PAUSE;
          end
        end else if (pause_ev) begin
          state_nxt = PAUSE;
        end else if (frame_tick && invuln != 8'd0) begin
          invuln_nxt = invuln - 8'd1;
        end
      end
      PAUSE: if (pause_ev || start_ev) state_nxt = PLAY;
      OVER:  if (start_ev) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      armed      <= 1'b0;
      lives      <= LIVES_INIT;
      invuln     <= 8'd0;
      char_rst   <= 1'b0;
      stepleft   <= 1'b0;
      stepright  <= 1'b0;
      stepjump   <= 1'b0;
    end else begin
      cnt        <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      frame_tick <= (cnt == CNT_MAX);
      start_prev <= btn_start;
      pause_prev <= btn_pause;
      armed      <= 1'b1;
      lives      <= lives_nxt;
      invuln     <= invuln_nxt;
      char_rst   <= crst_nxt;
      // gate on the next state so steps drop in the same cycle PLAY is left
      stepleft   <= (state_nxt == PLAY) & btn_left & ~btn_right;
      stepright  <= (state_nxt == PLAY) & btn_right & ~btn_left;
      stepjump   <= (state_nxt == PLAY) & btn_jump;
    end
  end
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game scenarios then random play, every cycle
// checked against a cycle-count based behavioural model of the game rules.
module tb_game_ctrl;
  localparam int P   = 10;
  localparam int LIV = 3;
  localparam int INV = 2;

  logic clk, rst_n;
  logic btn_left, btn_right, btn_jump, btn_start, btn_pause, player_hit;
  logic frame_tick, stepleft, stepright, stepjump, char_rst;
  logic [1:0] game_state, lives;

  game_ctrl #(.CLK_HZ(100), .FRAME_HZ(10), .LIVES(LIV), .INVULN_FRAMES(INV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
    .btn_jump(btn_jump), .btn_start(btn_start), .btn_pause(btn_pause),
    .player_hit(player_hit), .frame_tick(frame_tick), .stepleft(stepleft),
    .stepright(stepright), .stepjump(stepjump), .char_rst(char_rst),
    .game_state(game_state), .lives(lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err, ticks_seen, crst_seen;

  // model: 0=IDLE 1=PLAY 2=PAUSE 3=OVER; cyc = rising edges since reset release
  int m_state, m_lives, m_inv, cyc;
  bit m_tick, m_crst, m_sl, m_sr, m_sj, p_start, p_pause;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = LIV; m_inv = 0; cyc = 0;
    m_tick = 0; m_crst = 0; m_sl = 0; m_sr = 0; m_sj = 0;
    p_start = 0; p_pause = 0;
  endtask

  task automatic model_edge();
    bit ev_s, ev_p, play;
    int ns;
    if (!rst_n) begin model_reset(); return; end
    ev_s = (cyc > 0) && btn_start && !p_start;
    ev_p = (cyc > 0) && btn_pause && !p_pause;
    ns = m_state;
    m_crst = 0;
    case (m_state)
      0: if (ev_s) begin ns = 1; m_lives = LIV; m_inv = 0; m_crst = 1; end
      1: if (player_hit && m_inv == 0) begin
           if (m_lives == 1) begin m_lives = 0; ns = 3; end
           else begin
             m_lives = m_lives - 1; m_crst = 1; m_inv = INV;
             if (ev_p) ns = 2;
           end
         end else if (ev_p) ns = 2;
         else if (m_tick && m_inv > 0) m_inv = m_inv - 1;
      2: if (ev_p || ev_s) ns = 1;
      default: if (ev_s) ns = 0;
    endcase
    m_state = ns;
    play = (ns == 1);
    m_sl = play && btn_left && !btn_right;
    m_sr = play && btn_right && !btn_left;
    m_sj = play && btn_jump;
    p_start = btn_start;
    p_pause = btn_pause;
    cyc++;
    m_tick = (cyc % P == 0);
  endtask

  task automatic compare_all();
    chk("tick", frame_tick, m_tick);
    chk("char_rst", char_rst, m_crst);
    chk("state", game_state, m_state);
    chk("lives", lives, m_lives);
    chk("stepleft", stepleft, m_sl);
    chk("stepright", stepright, m_sr);
    chk("stepjump", stepjump, m_sj);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (frame_tick) ticks_seen++;
      if (char_rst) crst_seen++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_lives"}, lives, LIV);
    chk({tag, "_outs"}, {frame_tick, char_rst, stepleft, stepright, stepjump}, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; ticks_seen = 0; crst_seen = 0;
    {btn_left, btn_right, btn_jump, btn_pause, player_hit} = '0;
    btn_start = 1'b1;  // held through reset: must not start a game
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    run(2);
    rst_n = 1'b1;
    model_reset();
    run(3);
    chk("held_start", game_state, 0);
    btn_start = 1'b0;
    run(35);
    chk("tick_count", ticks_seen, 3);

    // start held 5 cycles: one transition, one char_rst
    crst_seen = 0;
    btn_start = 1'b1; run(5); btn_start = 1'b0; run(1);
    chk("start_state", game_state, 1);
    chk("start_crst", crst_seen, 1);

    btn_left = 1'b1; btn_right = 1'b1; run(2);
    chk("both_lr", {stepleft, stepright}, 0);
    btn_left = 1'b0; run(1);
    chk("right_only", stepright, 1);
    btn_right = 1'b0;

    // invulnerability window
    player_hit = 1'b1; run(1); player_hit = 1'b0;
    chk("hit1_lives", lives, 2);
    chk("hit1_crst", char_rst, 1);
    run(3);
    player_hit = 1'b1; run(1); player_hit = 1'b0;
    chk("invuln_hit", lives, 2);
    run(25);
    player_hit = 1'b1; run(1); player_hit = 1'b0;
    chk("hit2_lives", lives, 1);

    // pause freezes invuln and ignores hits
    btn_pause = 1'b1; run(1); btn_pause = 1'b0;
    chk("pause_state", game_state, 2);
    player_hit = 1'b1; run(1); player_hit = 1'b0;
    chk("pause_hit", lives, 1);
    run(30);
    btn_pause = 1'b1; run(1); btn_pause = 1'b0;
    chk("resume_state", game_state, 1);
    player_hit = 1'b1; run(1); player_hit = 1'b0;
    chk("frozen_invuln", lives, 1);

    // asynchronous reset mid-game
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_reset_outputs("async_rst");
    run(2);
    rst_n = 1'b1;
    model_reset();
    run(2);

    // play down to game over; final hit coincides with a pause event
    btn_start = 1'b1; run(1); btn_start = 1'b0; run(1);
    player_hit = 1'b1; run(1); player_hit = 1'b0; run(30);
    player_hit = 1'b1; run(1); player_hit = 1'b0; run(30);
    crst_seen = 0;
    player_hit = 1'b1; btn_pause = 1'b1; btn_left = 1'b1; run(1);
    player_hit = 1'b0; btn_pause = 1'b0;
    chk("over_state", game_state, 3);
    chk("over_lives", lives, 0);
    chk("over_steps", {stepleft, stepright, stepjump}, 0);
    chk("over_crst", crst_seen, 0);
    btn_left = 1'b0; run(3);
    btn_start = 1'b1; run(1); btn_start = 1'b0;
    chk("over_to_idle", game_state, 0);
    run(2);

    // random play
    for (int i = 0; i < 3000; i++) begin
      btn_left   = 1'($urandom_range(0, 1));
      btn_right  = 1'($urandom_range(0, 1));
      btn_jump   = 1'($urandom_range(0, 1));
      btn_start  = ($urandom_range(0, 19) == 0);
      btn_pause  = ($urandom_range(0, 24) == 0);
      player_hit = ($urandom_range(0, 7) == 0);
      run(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
